// File: rtl/hdmi_stream_timing.sv
// Raster timing generator plus AXI4-Stream frame aligner. Outputs are 1 clk_pix after hc/vc.
// Ready is combinational from registered state, raster position and valid/user; it is held low outside active mode 0.
module hdmi_stream_timing #(
  parameter int BPC      = 8,
  parameter int H_ACTIVE = 1366,
  parameter int H_FP     = 14,
  parameter int H_SYNC   = 56,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 28,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CW       = 12
) (
  input  logic                 clk_pix,
  input  logic                 reset_n,
  input  logic [1:0]           mode,
  input  logic [3*BPC-1:0]     solid_rgb,
  input  logic                 clr_status,
  input  logic [3*BPC-1:0]     s_axis_video_data,
  input  logic                 s_axis_video_valid,
  input  logic                 s_axis_video_user,
  input  logic                 s_axis_video_last,
  output logic                 s_axis_video_ready,
  output logic [CW-1:0]        sx,
  output logic [CW-1:0]        sy,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [3*BPC-1:0]     rgb,
  output logic                 locked,
  output logic                 underflow,
  output logic                 sync_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_EOL    = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

  typedef enum logic [1:0] {S_SEARCH, S_WAIT, S_LOCKED} state_t;

  logic [CW-1:0]      hc, vc;
  logic               hc_wrap, frame_end, origin;
  logic               de_i, hs_i, vs_i;
  logic [1:0]         act_mode;
  state_t             state_q, state_d;
  logic               rdy, take, set_uf, set_se;
  logic [CW-1:0]      bar_cnt;
  logic [2:0]         bar_idx;
  logic [2:0]         bar_bgr;
  logic [3*BPC-1:0]   bar_rgb;
  logic [3*BPC-1:0]   pix_d;

  assign hc_wrap   = (hc == H_LAST);
  assign frame_end = hc_wrap && (vc == V_LAST);
  assign origin    = (hc == '0) && (vc == '0);
  assign de_i      = (hc < H_ACT) && (vc < V_ACT);
  assign hs_i      = (hc >= HS_BEG) && (hc < HS_END);
  assign vs_i      = (vc >= VS_BEG) && (vc < VS_END);

  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (hc_wrap) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // Mode only changes at the frame boundary so a frame is never split between sources.
  always_ff @(posedge clk_pix) begin
    if (!reset_n || frame_end) act_mode <= mode;
  end

  always_ff @(posedge clk_pix) begin
    if (!reset_n) state_q <= S_SEARCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    take    = 1'b0;
    set_uf  = 1'b0;
    set_se  = 1'b0;
    if (act_mode != 2'd0) begin
      state_d = S_SEARCH;
    end else begin
      case (state_q)
        S_SEARCH: begin
          rdy = !(s_axis_video_valid && s_axis_video_user);
          if (s_axis_video_valid && s_axis_video_user) state_d = S_WAIT;
        end
        S_WAIT: begin
          rdy = origin;
          if (origin) begin
            if (s_axis_video_valid) begin
              take    = 1'b1;
              state_d = S_LOCKED;
            end else begin
              set_uf = 1'b1;
            end
          end
        end
        S_LOCKED: begin
          rdy = de_i && !(s_axis_video_valid && s_axis_video_user && !origin);
          // SOF waiting during blanking is the next frame's start, not an error.
          if (de_i) begin
            if (!s_axis_video_valid) begin
              set_uf  = 1'b1;
              state_d = S_SEARCH;
            end else if (s_axis_video_user && !origin) begin
              set_se  = 1'b1;
              state_d = S_WAIT;
            end else begin
              take = 1'b1;
            end
          end
        end
        default: state_d = S_SEARCH;
      endcase
      if (take && (s_axis_video_last != (hc == H_EOL))) begin
        set_se  = 1'b1;
        state_d = S_SEARCH;
      end
    end
  end

  assign s_axis_video_ready = rdy && reset_n;
  assign locked             = (state_q == S_LOCKED);

  always_ff @(posedge clk_pix) begin
    if (!reset_n || hc_wrap) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (bar_cnt == BAR_LAST) begin
      bar_cnt <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_cnt <= bar_cnt + 1'b1;
    end
  end

  always_comb begin
    case (bar_idx)
      3'd0:    bar_bgr = 3'b111;
      3'd1:    bar_bgr = 3'b011;
      3'd2:    bar_bgr = 3'b110;
      3'd3:    bar_bgr = 3'b010;
      3'd4:    bar_bgr = 3'b101;
      3'd5:    bar_bgr = 3'b001;
      3'd6:    bar_bgr = 3'b100;
      default: bar_bgr = 3'b000;
    endcase
    bar_rgb = {{BPC{bar_bgr[2]}}, {BPC{bar_bgr[1]}}, {BPC{bar_bgr[0]}}};
  end

  always_comb begin
    pix_d = '0;
    if (de_i) begin
      case (act_mode)
        2'd0:    pix_d = take ? s_axis_video_data : '0;
        2'd1:    pix_d = bar_rgb;
        2'd2:    pix_d = solid_rgb;
        default: pix_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      sx    <= '0;
      sy    <= '0;
      hsync <= !HS_POL;
      vsync <= !VS_POL;
      de    <= 1'b0;
      rgb   <= '0;
    end else begin
      sx    <= hc;
      sy    <= vc;
      hsync <= HS_POL ? hs_i : !hs_i;
      vsync <= VS_POL ? vs_i : !vs_i;
      de    <= de_i;
      rgb   <= pix_d;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!reset_n) begin
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      underflow <= set_uf || (underflow && !clr_status);
      sync_err  <= set_se || (sync_err && !clr_status);
    end
  end

endmodule

// File: tb/tb_hdmi_stream_timing.sv
// Directed bench for hdmi_stream_timing on a 22x7 raster (16x4 active).
module tb_hdmi_stream_timing;
  localparam int HA = 16, HT = 22, VA = 4, VT = 7;

  logic        clk_pix = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid_rgb = '0;
  logic        clr_status = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0, s_user = 1'b0, s_last = 1'b0;
  logic        s_ready;
  logic [11:0] sx, sy;
  logic        hsync, vsync, de, locked, underflow, sync_err;
  logic [23:0] rgb;

  int total = 0, bad = 0;
  int mh = 0, mv = 0, ph = 0, pv = 0;
  int spx = 0, spy = 0;
  bit src_en = 1'b0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                            24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};

  hdmi_stream_timing #(
    .BPC(8), .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(12)
  ) dut (
    .clk_pix(clk_pix), .reset_n(reset_n), .mode(mode), .solid_rgb(solid_rgb),
    .clr_status(clr_status), .s_axis_video_data(s_data), .s_axis_video_valid(s_valid),
    .s_axis_video_user(s_user), .s_axis_video_last(s_last), .s_axis_video_ready(s_ready),
    .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
    .locked(locked), .underflow(underflow), .sync_err(sync_err)
  );

  always #5 clk_pix = ~clk_pix;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] pix(input int x, input int y);
    if (x == 0 && y == 0) return 24'h123456;
    return {4'hC, 4'(y), 8'(x), 8'h5A};
  endfunction

  function automatic bit de_at(input int x, input int y);
    return (x < HA) && (y < VA);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    if (src_en) begin
      s_valid = 1'b1;
      s_data  = pix(spx, spy);
      s_user  = (spx == 0 && spy == 0);
      s_last  = (spx == HA - 1);
    end else begin
      s_valid = 1'b0;
      s_user  = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  // One clock; ph/pv become the raster position the outputs now show.
  task automatic tick();
    bit hs, rst;
    #1;
    hs  = s_valid && s_ready;
    rst = !reset_n;
    ph  = mh;
    pv  = mv;
    @(posedge clk_pix);
    #1;
    if (rst) begin
      mh = 0; mv = 0;
    end else if (mh == HT - 1) begin
      mh = 0; mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    if (hs && src_en) begin
      if (spx == HA - 1) begin
        spx = 0; spy = (spy == VA - 1) ? 0 : spy + 1;
      end else begin
        spx++;
      end
    end
  endtask

  task automatic step();
    drive_src();
    tick();
  endtask

  task automatic stream_to(input int x, input int y, input bit chk_lock);
    for (int i = 0; i < 400; i++) begin
      if (mh == x && mv == y) return;
      step();
      if (chk_lock) begin
        chk("lock_rgb", rgb, de_at(ph, pv) ? pix(ph, pv) : 24'h0);
        chk("lock_flag", locked, 1);
      end
    end
  endtask

  initial begin
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (25) tick();
    chk("pre_rst_sx", sx, 2);
    chk("pre_rst_de", de, 1);

    // Mid-frame reset with a non-SOF beat offered
    s_valid = 1'b1; s_user = 1'b0; reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_hsync", hsync, 0);
      chk("rst_vsync", vsync, 0);
      chk("rst_de", de, 0);
      chk("rst_rgb", rgb, 0);
      chk("rst_ready", s_ready, 0);
      chk("rst_sx", sx, 0);
      chk("rst_sy", sy, 0);
      chk("rst_flags", {locked, underflow, sync_err}, 0);
    end
    s_valid = 1'b0; reset_n = 1'b1;

    for (int i = 0; i < HT * VT; i++) begin
      tick();
      chk("ras_sx", sx, ph);
      chk("ras_sy", sy, pv);
      chk("ras_de", de, de_at(ph, pv));
      chk("ras_hsync", hsync, (ph >= 18 && ph <= 19));
      chk("ras_vsync", vsync, (pv == 5));
      chk("ras_rgb", rgb, 0);
    end

    // Junk beats drained mid-frame, then SOF held until origin
    repeat (30) tick();
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_user = 1'b0; s_last = 1'b0; s_data = 24'hDEAD00 + 24'(k);
      #1 chk("junk_ready", s_ready, 1);
      tick();
      chk("junk_hidden", rgb, 0);
    end
    src_en = 1'b1; spx = 0; spy = 0;
    drive_src();
    #1 chk("sof_held_ready", s_ready, 0);
    tick();
    drive_src();
    #1 chk("wait_ready", s_ready, 0);
    stream_to(0, 0, 0);
    drive_src();
    #1 chk("origin_ready", s_ready, 1);
    tick();
    chk("lock_sx", sx, 0);
    chk("lock_sy", sy, 0);
    chk("lock_de", de, 1);
    chk("lock_first_rgb", rgb, 24'h123456);
    chk("lock_locked", locked, 1);

    // Valid dropped at (3,1)
    stream_to(3, 1, 1);
    src_en = 1'b0;
    drive_src();
    #1 chk("drop_ready", s_ready, 1);
    tick();
    chk("drop_sx", sx, 3);
    chk("drop_rgb", rgb, 0);
    chk("drop_underflow", underflow, 1);
    chk("drop_locked", locked, 0);

    // Remaining frame drained, relock at next origin
    src_en = 1'b1;
    stream_to(0, 0, 0);
    drive_src();
    #1 chk("relock_ready", s_ready, 1);
    tick();
    chk("relock_rgb", rgb, 24'h123456);
    chk("relock_locked", locked, 1);
    chk("uf_sticky", underflow, 1);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("uf_cleared", underflow, 0);
    chk("uf_clr_rgb", rgb, pix(1, 0));

    // Early last at hc=5
    stream_to(5, 0, 1);
    drive_src();
    s_last = 1'b1;
    #1 chk("bad_last_ready", s_ready, 1);
    tick();
    chk("bad_last_sx", sx, 5);
    chk("bad_last_rgb", rgb, pix(5, 0));
    chk("sync_err_set", sync_err, 1);
    chk("sync_err_locked", locked, 0);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    chk("sync_err_cleared", sync_err, 0);
    chk("search_rgb", rgb, 0);

    // Relock, then request solid colour mid-frame
    stream_to(0, 0, 0);
    step();
    chk("relock2_rgb", rgb, 24'h123456);
    chk("relock2_locked", locked, 1);
    stream_to(0, 2, 1);
    mode = 2'd2; solid_rgb = 24'hABCDEF;
    stream_to(0, 0, 1);
    drive_src();
    #1 chk("solid_ready", s_ready, 0);
    tick();
    chk("solid_sx", sx, 0);
    chk("solid_sy", sy, 0);
    chk("solid_de", de, 1);
    chk("solid_rgb0", rgb, 24'hABCDEF);
    src_en = 1'b0;
    for (int i = 0; i < HT - 1; i++) begin
      step();
      chk("solid_rgb", rgb, de_at(ph, pv) ? 24'hABCDEF : 24'h0);
      chk("solid_locked", locked, 0);
    end

    // Colour bars, with a non-SOF beat offered throughout
    mode = 2'd1;
    s_valid = 1'b1; s_user = 1'b0; s_last = 1'b0;
    for (int i = 0; i < 400 && !(mh == 0 && mv == 0); i++) tick();
    for (int i = 0; i < HT; i++) begin
      #1 chk("bars_ready", s_ready, 0);
      tick();
      chk("bars_rgb", rgb, (ph < HA) ? bars[ph / 2] : 24'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hdmi_stream_timing.md
# hdmi_stream_timing

Parametrised pixel-clock timing generator and AXI4-Stream video frame aligner that sits between the video DMA stream and the three TMDS encoders. It generates hsync/vsync/de for any raster, applies real backpressure to the stream, and locks stream frames to the raster via tuser/tlast. It substitutes colour bars, a solid colour or black when the stream is absent, underflows or loses sync.

## Interface
- BPC, 8, bits per colour component
- H_ACTIVE / H_FP / H_SYNC / H_BP, 1366 / 14 / 56 / 64, horizontal active, front porch, sync, back porch (pixels)
- V_ACTIVE / V_FP / V_SYNC / V_BP, 768 / 1 / 3 / 28, vertical equivalents (lines)
- HS_POL / VS_POL, 1 / 1, sync active level
- CW, 12, sx/sy width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk_pix  in  1  pixel clock, sole clock
- reset_n  in  1  synchronous, active-low reset
- mode  in  2  0 stream, 1 colour bars, 2 solid, 3 blank
- solid_rgb  in  3*BPC  colour for mode 2
- clr_status  in  1  clears sticky flags
- s_axis_video_data  in  3*BPC  {B,G,R}, R in [BPC-1:0]
- s_axis_video_valid / _user / _last  in  1  AXI4-Stream video (user = SOF, last = EOL)
- s_axis_video_ready  out  1  backpressure
- sx, sy  out  CW  raster position of current outputs
- hsync, vsync, de  out  1  to encoders
- rgb  out  3*BPC  {B,G,R} pixel
- locked  out  1  state == LOCKED
- underflow, sync_err  out  1  sticky status

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Internal counters hc/vc: hc wraps at H_TOTAL-1, vc increments on wrap and wraps at V_TOTAL-1.
- de_i = hc<H_ACTIVE && vc<V_ACTIVE. hs_i = H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC. vs_i = V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, changing at hc==0. Output level = POL ? active : !active.
- Active mode latched from `mode` during reset and at hc==H_TOTAL-1 && vc==V_TOTAL-1 only; no mid-frame change.
- Stream FSM, used only in active mode 0; any other mode forces SEARCH, ready=0:
  - SEARCH: ready = !(valid && user). Non-SOF beats are drained. A valid SOF beat is held, not consumed → WAIT.
  - WAIT: ready = (hc==0 && vc==0). Accept → LOCKED. No valid at origin: set underflow, stay WAIT.
  - LOCKED: ready = de_i && !(valid && user && !(hc==0 && vc==0)). An unexpected SOF beat is not consumed; set sync_err → WAIT.
  - LOCKED, de_i && !valid: pixel = black, set underflow → SEARCH.
  - Accepted beat with last != (hc==H_ACTIVE-1): set sync_err → SEARCH; that pixel is still shown.
- Pixel source: mode 0 shows the accepted beat data, else black (not LOCKED or underflow). Mode 2 shows solid_rgb. Mode 3 shows black.
- Mode 1 shows 8 bars, BAR_W = H_ACTIVE/8 (localparam): white FFFFFF, yellow 00FFFF, cyan FFFF00, green 00FF00, magenta FF00FF, red 0000FF, blue FF0000, black 000000. Width is tracked by a bar pixel counter plus a 3-bit index, no divider. Index saturates at 7 for the remainder and resets at hc==0.
- rgb is forced to 0 whenever de_i == 0.
- Sticky flags set as above and clear on clr_status. Set wins over simultaneous clear.

## Timing
- Outputs sx, sy, hsync, vsync, de, rgb are registered together: latency exactly 1 clk_pix from hc/vc, so outputs stay mutually aligned.
- ready is combinational from registered state and hc/vc plus valid/user. It never depends on ready itself.
- A beat is consumed in cycle N (valid&&ready at hc=h) and appears on rgb in cycle N+1 with sx=h.
- Reset (reset_n low at posedge): hc, vc, sx, sy = 0. hsync=!HS_POL, vsync=!VS_POL, de=0, rgb=0, ready=0, locked=0, flags=0, FSM=SEARCH. Mid-frame reset restarts the raster at (0,0) next cycle.
- After release, hc=0 in the first cycle and increments each cycle. The first output has de=1 at sx=0,sy=0, one cycle after release.

## Test plan
Bench params: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1.
- Reset 5 cycles low mid-frame → hsync=0, vsync=0, de=0, rgb=0, ready=0. Release → sx 0,1,2…, hsync high for sx 18-19, vsync high on sy 5, de low for sx≥16.
- Mode 0, 3 junk beats then SOF beat 0x123456 mid-frame → junk consumed, SOF held with ready=0 until origin. Then rgb=0x123456 with sx=0, sy=0, de=1, locked=1.
- Locked stream, valid dropped at hc=3, vc=1 → rgb=0 at sx=3, underflow=1, locked=0. Relocks at next SOF/origin.
- Beat with last=1 at hc=5 → sync_err=1, FSM SEARCH. clr_status → sync_err=0.
- Mode 1 → each 2-pixel pair: FFFFFF, 00FFFF, FFFF00, 00FF00, FF00FF, 0000FF, FF0000, 000000. ready=0 throughout.
- Switch mode 0→2 (solid_rgb=0xABCDEF) at sy=2 → stream continues to frame end; solid 0xABCDEF from next frame's sx=0, sy=0.
